// File: rtl/key_schedule_store.sv
// AES key schedule (128/192/256 selectable per job): expands one word per cycle into a
// 60-word round-key store and serves 128-bit round keys in forward or inverse order.

module key_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, m;
        p = 8'h00;
        m = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as a^254 by square-and-multiply; 0 maps to 0 naturally.
    always_comb begin
        logic [7:0] x;
        x   = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            x   = gmul(x, x);
            inv = gmul(inv, x);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_schedule_store #(
    parameter int KMAX   = 256,
    parameter bit INV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      keyLen,
    input  logic [KMAX-1:0] key,
    output logic            busy,
    output logic            ready,
    output logic            err,
    output logic [3:0]      numRounds,
    input  logic [3:0]      rdIdx,
    input  logic            rdInv,
    output logic [127:0]    roundKey,
    output logic            rdValid
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
    state_t state, stateNxt;

    logic [3:0]  nk, nr, nkSel, nrSel;
    logic        legal, idleOrDone, accept;
    logic [7:0]  rcon;
    logic [5:0]  wIdx, lastIdx;
    logic [2:0]  modCnt, nkm1;
    logic [31:0] hist [8];
    logic [31:0] store [60];
    logic [255:0] keyPad;
    logic [31:0] keyW [8];
    logic [31:0] temp, tmpMix, newWord;
    logic [3:0][7:0] subIn, subOut;
    logic [3:0]  rdP;
    logic [5:0]  rdBase;

    always_comb begin
        legal = 1'b0;
        nkSel = 4'd4;
        nrSel = 4'd10;
        case (keyLen)
            2'b00: legal = 1'b1;
            2'b01: begin legal = (KMAX >= 192); nkSel = 4'd6; nrSel = 4'd12; end
            2'b10: begin legal = (KMAX >= 256); nkSel = 4'd8; nrSel = 4'd14; end
            default: legal = 1'b0;
        endcase
    end

    assign idleOrDone = (state == IDLE) || (state == DONE);
    assign accept     = start && idleOrDone && legal;
    assign busy       = (state == LOAD) || (state == EXPAND);
    assign ready      = (state == DONE);
    assign numRounds  = nr;
    assign lastIdx    = {nr, 2'b00} + 6'd3;
    assign nkm1       = 3'(nk - 4'd1);

    // Key is left-aligned; pad to 256 bits so word j always sits at the same slice.
    assign keyPad = 256'(key) << (256 - KMAX);
    for (genvar j = 0; j < 8; j++) begin : g_keyw
        assign keyW[j] = keyPad[255-32*j -: 32];
    end

    // History: hist[0] is w[i-Nk], hist[Nk-1] is w[i-1].
    assign temp  = hist[nkm1];
    assign subIn = (modCnt == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        key_sbox u_sbox (.a(subIn[g]), .s(subOut[g]));
    end

    always_comb begin
        tmpMix = temp;
        if (modCnt == 3'd0)
            tmpMix = subOut ^ {rcon, 24'h0};
        else if (nk == 4'd8 && modCnt == 3'd4)
            tmpMix = subOut;
        newWord = hist[0] ^ tmpMix;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE, DONE: if (accept) stateNxt = LOAD;
            LOAD:       stateNxt = EXPAND;
            EXPAND:     if (wIdx == lastIdx) stateNxt = DONE;
            default:    stateNxt = IDLE;
        endcase
    end

    assign rdP    = (INV_EN && rdInv) ? nr - rdIdx : rdIdx;
    assign rdBase = {rdP, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            nk       <= 4'd4;
            nr       <= 4'd0;
            rcon     <= 8'h01;
            wIdx     <= 6'd0;
            modCnt   <= 3'd0;
            roundKey <= '0;
            rdValid  <= 1'b0;
            for (int k = 0; k < 8; k++) hist[k] <= '0;
        end else begin
            err <= start && idleOrDone && !legal;
            if (accept) begin
                nk <= nkSel;
                nr <= nrSel;
            end
            if (state == LOAD) begin
                for (int k = 0; k < 8; k++) hist[k] <= keyW[k];
                rcon   <= 8'h01;
                wIdx   <= {2'b00, nk};
                modCnt <= 3'd0;
            end else if (state == EXPAND) begin
                for (int k = 0; k < 8; k++) begin
                    if (3'(k) == nkm1) hist[k] <= newWord;
                    else if (k < 7)    hist[k] <= hist[(k+1)%8];
                end
                wIdx   <= wIdx + 6'd1;
                modCnt <= (modCnt == nkm1) ? 3'd0 : modCnt + 3'd1;
                if (modCnt == 3'd0)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            // Read sees pre-edge ready, so a read coinciding with a new start returns the old schedule.
            rdValid <= ready && (rdIdx <= nr);
            if (ready && (rdIdx <= nr))
                roundKey <= {store[rdBase], store[rdBase+6'd1], store[rdBase+6'd2], store[rdBase+6'd3]};
            else
                roundKey <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int j = 0; j < 8; j++)
                if (4'(j) < nk) store[j] <= keyW[j];
        end else if (state == EXPAND) begin
            store[wIdx] <= newWord;
        end
    end
endmodule

// File: tb/tb_key_schedule_store.sv
// Self-checking bench for key_schedule_store: known-answer vectors plus randomized jobs
// compared against a textbook key-expansion model.

module tb_key_schedule_store;
    logic         clk = 1'b0;
    logic         reset, start, rdInv;
    logic [1:0]   keyLen;
    logic [255:0] key;
    logic         busy, ready, err, rdValid;
    logic [3:0]   numRounds, rdIdx;
    logic [127:0] roundKey;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_schedule_store #(.KMAX(256), .INV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .keyLen(keyLen), .key(key),
        .busy(busy), .ready(ready), .err(err), .numRounds(numRounds),
        .rdIdx(rdIdx), .rdInv(rdInv), .roundKey(roundKey), .rdValid(rdValid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from brute-force field inverse plus the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] c63 = 8'h63;
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gm(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        int nr = nk + 6;
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] mrk(input int p);
        return {mw[4*p], mw[4*p+1], mw[4*p+2], mw[4*p+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] kl, input logic [255:0] k);
        keyLen = kl;
        key    = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (ready) begin n = c; break; end
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic inv, output logic [127:0] rk, output logic v);
        rdIdx = idx;
        rdInv = inv;
        tick();
        rk = roundKey;
        v  = rdValid;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; keyLen = 2'b00; key = '0; rdIdx = '0; rdInv = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, ready, err, rdValid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {busy, ready, err, rdValid});
        end
        checks++;
        if (numRounds !== 4'd0 || roundKey !== 128'h0) begin
            errors++; $display("FAIL reset_regs got nr=%0d rk=%h want 0/0", numRounds, roundKey);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_aes128();
        int n;
        logic [127:0] rk;
        logic v;
        model_expand({K128, 128'h0}, 4);
        launch(2'b00, {K128, 128'h0});
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy128 got %b want 1", busy); end
        wait_ready(n);
        checks++;
        if (n !== 41) begin errors++; $display("FAIL lat128 got %0d want 41", n); end
        rd(4'd1, 1'b0, rk, v);
        checks++;
        if (rk !== R128_1 || v !== 1'b1) begin errors++; $display("FAIL r128_1 got %h/%b want %h/1", rk, v, R128_1); end
        rd(4'd10, 1'b0, rk, v);
        checks++;
        if (rk !== R128_10) begin errors++; $display("FAIL r128_10 got %h want %h", rk, R128_10); end
        rd(4'd0, 1'b0, rk, v);
        checks++;
        if (rk !== K128) begin errors++; $display("FAIL r128_0 got %h want %h", rk, K128); end
        for (int p = 0; p <= 10; p++) begin
            rd(4'(p), 1'b0, rk, v);
            checks++;
            if (rk !== mrk(p) || v !== 1'b1) begin errors++; $display("FAIL model128 p=%0d got %h want %h", p, rk, mrk(p)); end
        end
    endtask

    task automatic test_aes192();
        int n;
        logic [127:0] rk;
        logic v;
        launch(2'b01, {K192, 64'h0});
        wait_ready(n);
        checks++;
        if (n !== 47) begin errors++; $display("FAIL lat192 got %0d want 47", n); end
        checks++;
        if (numRounds !== 4'd12) begin errors++; $display("FAIL nr192 got %0d want 12", numRounds); end
        rd(4'd12, 1'b0, rk, v);
        checks++;
        if (rk !== R192_12 || v !== 1'b1) begin errors++; $display("FAIL r192_12 got %h want %h", rk, R192_12); end
    endtask

    task automatic test_aes256();
        int n;
        logic [127:0] rk;
        logic v;
        launch(2'b10, K256);
        wait_ready(n);
        checks++;
        if (n !== 53) begin errors++; $display("FAIL lat256 got %0d want 53", n); end
        rd(4'd0, 1'b1, rk, v);
        checks++;
        if (rk !== R256_14 || v !== 1'b1) begin errors++; $display("FAIL inv256_0 got %h want %h", rk, R256_14); end
        rd(4'd14, 1'b1, rk, v);
        checks++;
        if (rk !== K256[255:128]) begin errors++; $display("FAIL inv256_14 got %h want %h", rk, K256[255:128]); end
    endtask

    task automatic test_boundary();
        int n;
        logic [127:0] rk;
        logic v;
        launch(2'b00, {K128, 128'h0});
        for (int c = 1; c <= 120; c++) begin
            if (c == 11) begin keyLen = 2'b10; start = 1'b1; end
            tick();
            if (c == 11) begin
                start = 1'b0;
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL err_in_expand got %b want 0", err); end
            end
            if (ready) begin n = c; break; end
        end
        checks++;
        if (n !== 41 || numRounds !== 4'd10) begin errors++; $display("FAIL start_in_expand lat=%0d nr=%0d want 41/10", n, numRounds); end
        rd(4'd11, 1'b0, rk, v);
        checks++;
        if (rk !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL rd_oob got %h/%b want 0/0", rk, v); end
        keyLen = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || ready !== 1'b1 || numRounds !== 4'd10) begin
            errors++; $display("FAIL err_pulse got err=%b rdy=%b nr=%0d want 1/1/10", err, ready, numRounds);
        end
        tick();
        checks++;
        if (err !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL err_clear got err=%b rdy=%b want 0/1", err, ready); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] rk;
        logic v;
        launch(2'b00, {K128, 128'h0});
        for (int c = 1; c < 20; c++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || numRounds !== 4'd0) begin
            errors++; $display("FAIL async_reset got busy=%b rdy=%b nr=%0d want 0/0/0", busy, ready, numRounds);
        end
        tick();
        reset = 1'b1;
        rd(4'd0, 1'b0, rk, v);
        checks++;
        if (v !== 1'b0 || rk !== 128'h0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got v=%b busy=%b want 0/0", v, busy); end
        launch(2'b00, {K128, 128'h0});
        wait_ready(n);
        checks++;
        if (n !== 41) begin errors++; $display("FAIL lat_restart got %0d want 41", n); end
        rd(4'd10, 1'b0, rk, v);
        checks++;
        if (rk !== R128_10) begin errors++; $display("FAIL r10_restart got %h want %h", rk, R128_10); end
    endtask

    task automatic test_back_to_back();
        int n = -1;
        logic [127:0] rk;
        logic v;
        rdIdx = 4'd10; rdInv = 1'b0;
        launch(2'b10, K256);
        checks++;
        if (rdValid !== 1'b1 || roundKey !== R128_10 || ready !== 1'b0) begin
            errors++; $display("FAIL b2b_old got %h/%b rdy=%b want %h/1/0", roundKey, rdValid, ready, R128_10);
        end
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (c == 5) begin
                checks++;
                if (rdValid !== 1'b0) begin errors++; $display("FAIL b2b_busy_read got %b want 0", rdValid); end
            end
            if (ready) begin n = c; break; end
        end
        checks++;
        if (n !== 53) begin errors++; $display("FAIL lat_b2b got %0d want 53", n); end
        rd(4'd0, 1'b1, rk, v);
        checks++;
        if (rk !== R256_14 || v !== 1'b1) begin errors++; $display("FAIL b2b_new got %h want %h", rk, R256_14); end
    endtask

    task automatic test_random();
        int n, nk, nr, idx;
        logic [1:0] kl;
        logic [255:0] k;
        logic [127:0] rk, exp;
        logic v, inv, expv;
        for (int job = 0; job < 4; job++) begin
            kl = 2'($urandom_range(0, 2));
            nk = 4 + 2*int'(kl);
            nr = nk + 6;
            for (int w = 0; w < 8; w++) k[255-32*w -: 32] = $urandom;
            model_expand(k, nk);
            launch(kl, k);
            wait_ready(n);
            checks++;
            if (n !== 1 + 4*(nr+1) - nk) begin errors++; $display("FAIL rnd_lat job=%0d got %0d want %0d", job, n, 1 + 4*(nr+1) - nk); end
            for (int r = 0; r < 8; r++) begin
                idx = $urandom_range(0, nr + 1);
                inv = 1'($urandom_range(0, 1));
                expv = (idx <= nr);
                exp  = expv ? mrk(inv ? nr - idx : idx) : 128'h0;
                rd(4'(idx), inv, rk, v);
                checks++;
                if (rk !== exp || v !== expv) begin
                    errors++; $display("FAIL rnd_rd job=%0d idx=%0d inv=%b got %h/%b want %h/%b", job, idx, inv, rk, v, exp, expv);
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_schedule_store.md
Name: key_schedule_store

Overview:
- Runtime-configurable AES key schedule. Selects 128/192/256-bit keys per job, with no rebuild.
- Expands the key one 32-bit word per cycle into an internal round-key store (up to 60 words).
- Serves any round key on a registered random-access read port, in forward (encrypt) or inverse (decrypt) order.
- Sits between the key-load interface and the cipher/inverse-cipher round datapaths.

Parameters:
- KMAX, 256, widest supported key in bits (legal values 128/192/256); the key port is KMAX bits wide.
- INV_EN, 1, when 0, rdInv is ignored and forward order is always used.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; clears all control state immediately.
- start, input, 1, request to expand key; sampled only in IDLE or DONE.
- keyLen, input, 2, 00=128, 01=192, 10=256, 11=illegal; sampled with start.
- key, input, KMAX, key left-aligned: word w[0] in key[KMAX-1:KMAX-32]; unused low bits ignored.
- busy, output, 1, high in LOAD/EXPAND.
- ready, output, 1, high in DONE: the schedule is complete and readable.
- err, output, 1, one-cycle pulse when start arrives with an illegal keyLen (11, or a length above KMAX).
- numRounds, output, 4, Nr of the latched job (10/12/14); 0 after reset.
- rdIdx, input, 4, requested round index 0..Nr.
- rdInv, input, 1, 1 = inverse order, so physical round = Nr - rdIdx.
- roundKey, output, 128, words w[4p..4p+3]; w[4p] in [127:96].
- rdValid, output, 1, qualifies roundKey.

Behaviour:
- Reset (async, low) clears the following; it applies mid-expansion too, aborting the job:
  - state to IDLE;
  - ready, busy, err, rdValid, numRounds to 0;
  - roundKey to 0;
  - Rcon to 0x01;
  - word counter to 0.
- The store array is not reset; its contents are unreadable until the next DONE.
- FSM IDLE -> LOAD -> EXPAND -> DONE.
  - IDLE/DONE + start + legal keyLen: go to LOAD; latch Nk (4/6/8) and Nr (10/12/14).
  - IDLE/DONE + start + illegal keyLen: stay in the current state and pulse err for one cycle.
  - start in LOAD or EXPAND: ignored, no err.
  - LOAD (1 cycle): writes w[0..Nk-1] from key; preloads the Nk-deep history shift register; Rcon=0x01; i=Nk.
  - EXPAND: one word per cycle, i = Nk .. 4(Nr+1)-1.
    - temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon) (reduction polynomial 0x11B).
    - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp; write to store and shift into history.
  - EXPAND ends after word 4(Nr+1)-1 is written; next state is DONE.
- Latency: start sampled at edge 0 means ready=1 after edge 1+(4(Nr+1)-Nk).
  - 41 cycles for AES-128.
  - 47 cycles for AES-192.
  - 53 cycles for AES-256.
- ready is deasserted on the edge that accepts a new start out of DONE.
- Read port (1-cycle registered):
  - Physical round p = rdInv ? Nr-rdIdx : rdIdx.
  - At the next edge: roundKey = w[4p..4p+3], rdValid = 1, provided ready=1 and rdIdx<=Nr.
  - Otherwise roundKey=0 and rdValid=0. This covers rdIdx>Nr, a read while busy, and a read after reset.
- Simultaneous read and accepted start in DONE: the read returns the old schedule with rdValid=1, because sampling happens pre-edge. Later reads are blocked until the new DONE.
- SubWord uses 4 parallel S-box lookups, combinational, one per cycle. The Rcon sequence is 01,02,04,...,80,1B,36; at most 10 values are used (AES-128).

Test Plan:
- Reset, then AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
  - ready rises at edge 41.
  - rdIdx=1 gives a0fafe1788542cb123a339392a6c7605.
  - rdIdx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rdIdx=0 gives the key.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-aligned):
  - numRounds=12; ready at edge 47.
  - rdIdx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - ready at edge 53.
  - rdInv=1, rdIdx=0 gives fe4890d1e6188d0b046df344706c631e.
  - rdInv=1, rdIdx=14 gives the first 128 key bits.
- Boundaries:
  - rdIdx=11 with Nr=10 gives rdValid=0, roundKey=0.
  - keyLen=11 with start gives a 1-cycle err pulse and no state change.
  - start during EXPAND is ignored; ready timing is unchanged.
- reset low at edge 20 of AES-128 expansion:
  - busy/ready drop immediately and state is IDLE.
  - A restart with the same key still gives the round-10 value above at edge 41.
- Back-to-back jobs from DONE (128 then 256):
  - A same-cycle read returns the old round key.
  - ready is low for 53 cycles, then the new values appear.
